retire_rob: RTL and testbench
=============================

RETIRE_ROB -- requirements
Module: retire_rob

Interface
REQ-001 Parameter DEPTH, default 16, number of ROB entries (power of two).
REQ-002 Parameter IDX_W, default 4, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  discard all in-flight entries.
REQ-006 alloc_valid  input  1  rename/dispatch offers one instruction.
REQ-007 alloc_ready  output  1  ROB can accept an entry this cycle.
REQ-008 alloc_rd  input  5  architectural destination register.
REQ-009 alloc_pd  input  6  newly mapped physical destination.
REQ-010 alloc_old_pd  input  6  previous physical mapping of rd, freed at retire.
REQ-011 alloc_idx  output  IDX_W  ROB index the offered entry receives (current tail).
REQ-012 cmp_valid  input  1  execution unit reports completion.
REQ-013 cmp_idx  input  IDX_W  ROB index being completed.
REQ-014 cmp_value  input  32  result value.
REQ-015 retire_valid  output  1  one instruction committed (registered pulse).
REQ-016 retire_rd  output  5  architectural register written.
REQ-017 retire_pd  output  6  physical register now architecturally committed.
REQ-018 retire_value  output  32  committed result.
REQ-019 free_valid  output  1  old physical register returned to free pool.
REQ-020 free_pd  output  6  physical register being freed.
REQ-021 count  output  IDX_W+1  occupied entries.

Function
REQ-022 Each entry holds valid, complete, rd, pd, old_pd, value; head, tail pointers IDX_W bits, wrap modulo DEPTH.
REQ-023 alloc_ready = (count < DEPTH) and not flush; depends on current count only, not on a same-cycle retire.
REQ-024 Handshake alloc_valid & alloc_ready at edge: entry[tail] written valid=1, complete=0; tail increments; alloc_idx is combinational = tail.
REQ-025 cmp_valid at edge: if entry[cmp_idx].valid, set complete=1 and store cmp_value; completion to an invalid entry ignored, no state change.
REQ-026 Retire decision: at an edge where entry[head].valid & entry[head].complete, entry cleared, head increments, retire outputs loaded; at most one retire per cycle, strictly in order.
REQ-027 Minimum latency: completion captured at edge N; retire outputs asserted after edge N+1 for exactly one cycle.
REQ-028 retire_valid=0 on cycles with no retire; retire_rd/pd/value hold last values then.
REQ-029 free_valid = retire_valid and retire_rd != 0; free_pd = entry old_pd; rd==0 entries retire with free_valid=0.
REQ-030 count updates: +1 on alloc, -1 on retire, unchanged when both or neither occur same edge.
REQ-031 Full (count==DEPTH): alloc_ready=0 even if head retires same cycle; next cycle alloc_ready=1.
REQ-032 Empty (count==0): no retire; completion ignored per REQ-025.
REQ-033 flush at edge: all valid bits cleared, head=tail=0, count=0, retire_valid=0, free_valid=0; overrides alloc, cmp and retire in that cycle.
REQ-034 Completion to head in the same cycle head is evaluated does not retire that cycle (complete bit must be registered first).

Reset
REQ-035 rst_n low asynchronously: head=tail=0, count=0, all valid/complete=0, retire_valid=0, free_valid=0, retire_rd=0, retire_pd=0, retire_value=0, free_pd=0.
REQ-036 Reset mid-operation discards all entries; alloc_ready=1 on first cycle after rst_n rises.
REQ-037 Entry payload fields (rd, pd, old_pd, value) need no reset.

Verification
REQ-038 Alloc rd=5,pd=33,old_pd=5 at idx 0; complete idx 0 value 0xDEADBEEF -> next cycle retire_valid=1, rd=5, pd=33, value=0xDEADBEEF, free_valid=1, free_pd=5.
REQ-039 Alloc idx 0,1,2; complete 2 then 1 then 0 -> retires in order 0,1,2, one per cycle, none before idx 0 completes.
REQ-040 Fill 16 entries -> alloc_ready=0, count=16; complete head -> retire, count=15, alloc_ready=1; tail wraps to 0 on next alloc.
REQ-041 Alloc rd=0 and complete -> retire_valid=1, free_valid=0.
REQ-042 Five entries in flight, two complete, assert flush -> count=0, no retire_valid next cycle, late cmp_valid to old index ignored.
REQ-043 Drive rst_n low between edges with entries pending -> outputs zero immediately, before next clk edge.

Source files
------------

// File: rtl/retire_rob.sv
// rtl/retire_rob.sv - in-order reorder buffer: allocate at tail, complete by index, retire one per cycle from head
module retire_rob #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [4:0]       alloc_rd,
   input  logic [5:0]       alloc_pd,
   input  logic [5:0]       alloc_old_pd,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             cmp_valid,
   input  logic [IDX_W-1:0] cmp_idx,
   input  logic [31:0]      cmp_value,
   output logic             retire_valid,
   output logic [4:0]       retire_rd,
   output logic [5:0]       retire_pd,
   output logic [31:0]      retire_value,
   output logic             free_valid,
   output logic [5:0]       free_pd,
   output logic [IDX_W:0]   count
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   logic [DEPTH-1:0] ent_valid;
   logic [DEPTH-1:0] ent_complete;
   logic [4:0]       ent_rd     [DEPTH];
   logic [5:0]       ent_pd     [DEPTH];
   logic [5:0]       ent_old_pd [DEPTH];
   logic [31:0]      ent_value  [DEPTH];

   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;

   logic do_alloc;
   logic do_cmp;
   logic do_retire;

   // Ready looks only at the registered count, so a full ROB stays closed
   // for the cycle in which its head retires.
   assign alloc_ready = (count < FULL_COUNT) && !flush;
   assign alloc_idx   = tail;
   assign do_alloc    = alloc_valid && alloc_ready;
   assign do_cmp      = cmp_valid && ent_valid[cmp_idx];
   assign do_retire   = ent_valid[head] && ent_complete[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid    <= '0;
         ent_complete <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         retire_valid <= 1'b0;
         free_valid   <= 1'b0;
         retire_rd    <= '0;
         retire_pd    <= '0;
         retire_value <= '0;
         free_pd      <= '0;
      end else if (flush) begin
         ent_valid    <= '0;
         ent_complete <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         retire_valid <= 1'b0;
         free_valid   <= 1'b0;
      end else begin
         if (do_alloc) begin
            ent_valid[tail]    <= 1'b1;
            ent_complete[tail] <= 1'b0;
            tail               <= tail + 1'b1;
         end
         if (do_cmp) begin
            ent_complete[cmp_idx] <= 1'b1;
         end
         // Retire clear is last so it wins over a redundant completion to the head.
         if (do_retire) begin
            ent_valid[head]    <= 1'b0;
            ent_complete[head] <= 1'b0;
            head               <= head + 1'b1;
            retire_rd          <= ent_rd[head];
            retire_pd          <= ent_pd[head];
            retire_value       <= ent_value[head];
            free_pd            <= ent_old_pd[head];
         end
         retire_valid <= do_retire;
         free_valid   <= do_retire && (ent_rd[head] != 5'd0);
         case ({do_alloc, do_retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent_rd[tail]     <= alloc_rd;
         ent_pd[tail]     <= alloc_pd;
         ent_old_pd[tail] <= alloc_old_pd;
      end
      if (do_cmp && !flush) begin
         ent_value[cmp_idx] <= cmp_value;
      end
   end

endmodule

// File: tb/tb_retire_rob.sv
// tb/tb_retire_rob.sv - scoreboard bench for retire_rob
module tb_retire_rob;

   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             alloc_valid = 1'b0;
   logic             alloc_ready;
   logic [4:0]       alloc_rd = '0;
   logic [5:0]       alloc_pd = '0;
   logic [5:0]       alloc_old_pd = '0;
   logic [IDX_W-1:0] alloc_idx;
   logic             cmp_valid = 1'b0;
   logic [IDX_W-1:0] cmp_idx = '0;
   logic [31:0]      cmp_value = '0;
   logic             retire_valid;
   logic [4:0]       retire_rd;
   logic [5:0]       retire_pd;
   logic [31:0]      retire_value;
   logic             free_valid;
   logic [5:0]       free_pd;
   logic [IDX_W:0]   count;

   retire_rob #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .alloc_valid  (alloc_valid),
      .alloc_ready  (alloc_ready),
      .alloc_rd     (alloc_rd),
      .alloc_pd     (alloc_pd),
      .alloc_old_pd (alloc_old_pd),
      .alloc_idx    (alloc_idx),
      .cmp_valid    (cmp_valid),
      .cmp_idx      (cmp_idx),
      .cmp_value    (cmp_value),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd),
      .retire_pd    (retire_pd),
      .retire_value (retire_value),
      .free_valid   (free_valid),
      .free_pd      (free_pd),
      .count        (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0]       m_rd  [DEPTH];
   logic [5:0]       m_pd  [DEPTH];
   logic [5:0]       m_opd [DEPTH];
   logic [31:0]      m_val [DEPTH];
   logic [IDX_W-1:0] m_tail = '0;
   int               sb[$];
   int               mon_idx;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [4:0] rd, input logic [5:0] pd, input logic [5:0] opd);
      check("alloc_ready", alloc_ready, 1);
      check("alloc_idx", alloc_idx, m_tail);
      alloc_valid  = 1'b1;
      alloc_rd     = rd;
      alloc_pd     = pd;
      alloc_old_pd = opd;
      step(1);
      alloc_valid  = 1'b0;
      m_rd[m_tail]  = rd;
      m_pd[m_tail]  = pd;
      m_opd[m_tail] = opd;
      sb.push_back(int'(m_tail));
      m_tail++;
   endtask

   task automatic do_cmp(input logic [IDX_W-1:0] idx, input logic [31:0] v);
      cmp_valid = 1'b1;
      cmp_idx   = idx;
      cmp_value = v;
      step(1);
      cmp_valid = 1'b0;
      m_val[idx] = v;
   endtask

   // Every retire pulse is matched against the oldest outstanding allocation.
   always @(negedge clk) begin
      if (rst_n && retire_valid) begin
         if (sb.size() == 0) begin
            check("spurious_retire", 1, 0);
         end else begin
            mon_idx = sb.pop_front();
            check("sb_rd", retire_rd, m_rd[mon_idx]);
            check("sb_pd", retire_pd, m_pd[mon_idx]);
            check("sb_value", retire_value, m_val[mon_idx]);
            check("sb_free_valid", free_valid, m_rd[mon_idx] != 5'd0);
            if (m_rd[mon_idx] != 5'd0) check("sb_free_pd", free_pd, m_opd[mon_idx]);
         end
      end
   end

   initial begin
      #12;
      check("rst_retire_valid", retire_valid, 0);
      check("rst_free_valid", free_valid, 0);
      check("rst_retire_rd", retire_rd, 0);
      check("rst_retire_pd", retire_pd, 0);
      check("rst_retire_value", retire_value, 0);
      check("rst_free_pd", free_pd, 0);
      check("rst_count", count, 0);
      check("rst_alloc_idx", alloc_idx, 0);
      rst_n = 1'b1;
      step(1);
      check("post_rst_ready", alloc_ready, 1);

      // single entry, minimum latency
      do_alloc(5'd5, 6'd33, 6'd5);
      check("count_one", count, 1);
      do_cmp(4'd0, 32'hDEADBEEF);
      check("lat_not_early", retire_valid, 0);
      step(1);
      check("lat_retire_valid", retire_valid, 1);
      check("lat_retire_rd", retire_rd, 5);
      check("lat_retire_pd", retire_pd, 33);
      check("lat_retire_value", retire_value, 32'hDEADBEEF);
      check("lat_free_valid", free_valid, 1);
      check("lat_free_pd", free_pd, 5);
      check("lat_count", count, 0);
      step(1);
      check("pulse_one_cycle", retire_valid, 0);
      check("free_one_cycle", free_valid, 0);
      check("hold_retire_rd", retire_rd, 5);

      // out-of-order completion, in-order retire
      do_alloc(5'd1, 6'd40, 6'd10);
      do_alloc(5'd2, 6'd41, 6'd11);
      do_alloc(5'd3, 6'd42, 6'd12);
      do_cmp(4'd3, 32'h3333);
      do_cmp(4'd2, 32'h2222);
      step(2);
      check("ooo_no_early", retire_valid, 0);
      check("ooo_count", count, 3);
      do_cmp(4'd1, 32'h1111);
      check("ooo_head_not_same_cycle", retire_valid, 0);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         check("ooo_retire_valid", retire_valid, 1);
         check("ooo_retire_rd", retire_rd, i);
      end
      step(1);
      check("ooo_done", retire_valid, 0);
      check("ooo_count_zero", count, 0);

      // rd == 0 retires without freeing
      do_alloc(5'd0, 6'd50, 6'd20);
      do_cmp(4'd4, 32'h0BADF00D);
      step(1);
      check("rd0_retire_valid", retire_valid, 1);
      check("rd0_free_valid", free_valid, 0);
      step(1);

      // flush with five in flight, two complete
      for (int i = 0; i < 5; i++) do_alloc(5'(6 + i), 6'(i), 6'(i + 8));
      do_cmp(4'd6, 32'h66);
      do_cmp(4'd7, 32'h77);
      check("pre_flush_count", count, 5);
      flush = 1'b1;
      alloc_valid = 1'b1;
      #1;
      check("ready_in_flush", alloc_ready, 0);
      step(1);
      flush = 1'b0;
      alloc_valid = 1'b0;
      sb.delete();
      m_tail = '0;
      check("flush_count", count, 0);
      check("flush_alloc_idx", alloc_idx, 0);
      check("flush_retire_valid", retire_valid, 0);
      check("flush_free_valid", free_valid, 0);
      cmp_valid = 1'b1;
      cmp_idx = 4'd6;
      cmp_value = 32'hBAD;
      step(1);
      cmp_valid = 1'b0;
      step(2);
      check("stale_cmp_no_retire", retire_valid, 0);
      check("stale_cmp_count", count, 0);

      // fill, full boundary, wrap
      for (int i = 0; i < DEPTH; i++) do_alloc(5'(i + 1), 6'(i), 6'(i + 32));
      check("full_count", count, 16);
      check("full_ready", alloc_ready, 0);
      do_cmp(4'd0, 32'hF00D0000);
      check("full_ready_on_retire_cycle", alloc_ready, 0);
      step(1);
      check("full_retire_valid", retire_valid, 1);
      check("after_full_count", count, 15);
      check("after_full_ready", alloc_ready, 1);
      do_alloc(5'd17, 6'd60, 6'd61);
      check("wrap_count", count, 16);
      for (int i = 1; i < DEPTH; i++) do_cmp(4'(i), 32'hA000 + i);
      do_cmp(4'd0, 32'hC0FFEE);
      step(4);
      check("drain_count", count, 0);
      check("sb_drained", sb.size(), 0);

      // asynchronous reset between edges
      do_alloc(5'd9, 6'd62, 6'd30);
      do_alloc(5'd10, 6'd63, 6'd31);
      do_cmp(m_tail - 4'd2, 32'h12345678);
      step(1);
      check("pre_arst_retire", retire_valid, 1);
      check("pre_arst_count", count, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_retire_valid", retire_valid, 0);
      check("arst_free_valid", free_valid, 0);
      check("arst_retire_rd", retire_rd, 0);
      check("arst_retire_pd", retire_pd, 0);
      check("arst_retire_value", retire_value, 0);
      check("arst_free_pd", free_pd, 0);
      check("arst_count", count, 0);
      sb.delete();
      m_tail = '0;
      #3;
      rst_n = 1'b1;
      step(1);
      check("post_arst_ready", alloc_ready, 1);
      check("post_arst_idx", alloc_idx, 0);
      step(2);
      check("post_arst_no_retire", retire_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
